automaton_row_engine: RTL and testbench

AUTOMATON_ROW_ENGINE -- requirements
Module: automaton_row_engine

---
 rtl/automaton_row_engine_if.sv | 15 +
 rtl/automaton_row_engine.sv | 130 +++++++++++++
 tb/tb_automaton_row_engine.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/automaton_row_engine_if.sv
// Control and frame-buffer write bus of the automaton row engine.
// master drives the frame request; slave (the engine) drives the write port and status.
interface automaton_row_engine_if;
  logic        start;
  logic [7:0]  rule;
  logic        cont;
  logic [15:0] address_a;
  logic [19:0] data_a;
  logic        wren_a;
  logic        busy;
  logic        done;

  modport master (output start, rule, cont, input address_a, data_a, wren_a, busy, done);
  modport slave  (input start, rule, cont, output address_a, data_a, wren_a, busy, done);
endinterface

// File: rtl/automaton_row_engine.sv
// Elementary cellular-automaton frame generator: writes ROWS x 1280 cells, one 20-cell word per cycle.
// First write the cycle after start; each generated row is 2 idle cycles then 64 writes; no backpressure.
module automaton_row_engine #(
  parameter int ROWS = 1024
) (
  input  logic                  clk108,
  input  logic                  reset,
  automaton_row_engine_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SEED, GEN, FIN} state_t;
  localparam logic [9:0] LAST_ROW = 10'(ROWS - 1);

  state_t      state_q;
  logic [6:0]  cnt_q;
  logic [9:0]  row_q;
  logic [5:0]  wptr_q;
  logic        left_q;
  logic [7:0]  rule_q;
  logic        seed_q;
  logic        lrv_q;
  logic [19:0] rb_q [64];
  logic [15:0] addr_q;
  logic [19:0] data_q;
  logic        wren_q;
  logic        busy_q;
  logic        done_q;

  logic        issue;
  logic [7:0]  rule_eff;
  logic        seed_eff;
  logic [5:0]  wptr_nx;
  logic [21:0] nbhd;
  logic [19:0] gen_word;
  logic [19:0] new_word;

  // A write is launched on the edge that enters its output cycle.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      IDLE:    issue = bus.start;
      SEED:    issue = (cnt_q != 7'd63);
      GEN:     issue = (cnt_q >= 7'd1) && (cnt_q <= 7'd64);
      default: issue = 1'b0;
    endcase
  end

  assign rule_eff = (state_q == IDLE) ? bus.rule : rule_q;
  assign seed_eff = (state_q == IDLE) ? !(bus.cont && lrv_q) : ((state_q == SEED) && seed_q);
  assign wptr_nx  = wptr_q + 6'd1;

  // Words are overwritten in place; left_q keeps the old bit 19 of the word just replaced.
  assign nbhd = {(wptr_q == 6'd63) ? 1'b0 : rb_q[wptr_nx][0],
                 rb_q[wptr_q],
                 (wptr_q == 6'd0) ? 1'b0 : left_q};

  always_comb begin
    gen_word = '0;
    for (int b = 0; b < 20; b++) begin
      gen_word[b] = rule_eff[{nbhd[b], nbhd[b+1], nbhd[b+2]}];
    end
    new_word = seed_eff ? ((wptr_q == 6'd32) ? 20'h00001 : 20'h00000) : gen_word;
  end

  always_ff @(posedge clk108 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      wptr_q  <= '0;
      left_q  <= 1'b0;
      rule_q  <= '0;
      seed_q  <= 1'b1;
      lrv_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 64; i++) rb_q[i] <= '0;
    end else begin
      wren_q <= issue;
      done_q <= 1'b0;
      if (issue) begin
        addr_q       <= {(state_q == GEN) ? row_q : 10'd0, wptr_q};
        data_q       <= new_word;
        rb_q[wptr_q] <= new_word;
        left_q       <= rb_q[wptr_q][19];
        wptr_q       <= wptr_nx;
      end
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= SEED;
          rule_q  <= bus.rule;
          seed_q  <= !(bus.cont && lrv_q);
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          row_q   <= '0;
        end
        SEED: if (cnt_q == 7'd63) begin
          state_q <= GEN;
          cnt_q   <= '0;
          row_q   <= 10'd1;
        end else begin
          cnt_q <= cnt_q + 7'd1;
        end
        GEN: if (cnt_q == 7'd65) begin
          cnt_q <= '0;
          if (row_q == LAST_ROW) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            lrv_q   <= 1'b1;
          end else begin
            row_q <= row_q + 10'd1;
          end
        end else begin
          cnt_q <= cnt_q + 7'd1;
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.address_a = addr_q;
  assign bus.data_a    = data_q;
  assign bus.wren_a    = wren_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_automaton_row_engine.sv
// Bench: a short-frame engine checked cycle by cycle against a row-level automaton model,
// plus a full-size engine running one rule-0 frame for exact length and write count.
module tb_automaton_row_engine;
  localparam int SROWS = 8;
  localparam int SLEN  = 64 + (SROWS - 1) * 66;
  localparam int BLEN  = 67582;

  typedef logic [1279:0] row_t;

  logic clk108 = 1'b0;
  logic rst_s  = 1'b1;
  logic rst_b  = 1'b1;

  automaton_row_engine_if s_if();
  automaton_row_engine_if b_if();

  automaton_row_engine #(.ROWS(SROWS)) dut_s (.clk108(clk108), .reset(rst_s), .bus(s_if));
  automaton_row_engine                 dut_b (.clk108(clk108), .reset(rst_b), .bus(b_if));

  always #5 clk108 = ~clk108;

  int n_cmp = 0;
  int n_bad = 0;
  bit big_done = 1'b0;

  row_t        exp_rows [SROWS];
  row_t        last_row = '0;
  logic [19:0] s_mem [SROWS*64];
  bit          m_active = 1'b0;
  bit          m_lrv = 1'b0;
  int          m_k = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic row_t succ(input row_t old, input logic [7:0] rl);
    row_t n;
    logic l, c, r;
    for (int x = 0; x < 1280; x++) begin
      l = (x > 0) ? old[x-1] : 1'b0;
      c = old[x];
      r = (x < 1279) ? old[x+1] : 1'b0;
      n[x] = rl[{l, c, r}];
    end
    return n;
  endfunction

  // Frame-level model: accepts start only while no frame is in flight, builds every row up front.
  always @(posedge clk108 or posedge rst_s) begin
    if (rst_s) begin
      m_active = 1'b0;
      m_lrv    = 1'b0;
    end else if (m_active) begin
      m_k++;
      if (m_k > SLEN + 1) begin
        m_active = 1'b0;
        m_lrv    = 1'b1;
        last_row = exp_rows[SROWS-1];
      end
    end else if (s_if.start) begin
      if (s_if.cont && m_lrv) exp_rows[0] = succ(last_row, s_if.rule);
      else begin
        exp_rows[0] = '0;
        exp_rows[0][640] = 1'b1;
      end
      for (int r = 1; r < SROWS; r++) exp_rows[r] = succ(exp_rows[r-1], s_if.rule);
      m_active = 1'b1;
      m_k      = 1;
    end
  end

  always @(negedge clk108) begin : s_compare
    bit ew;
    int er, ewd, j;
    if (rst_s) begin
      check("s_rst_wren", s_if.wren_a, 0);
      check("s_rst_busy", s_if.busy, 0);
      check("s_rst_done", s_if.done, 0);
      check("s_rst_addr", s_if.address_a, 0);
      check("s_rst_data", s_if.data_a, 0);
    end else if (!m_active) begin
      check("s_idle_wren", s_if.wren_a, 0);
      check("s_idle_busy", s_if.busy, 0);
      check("s_idle_done", s_if.done, 0);
    end else begin
      ew = 1'b0; er = 0; ewd = 0;
      if (m_k <= 64) begin
        ew = 1'b1; ewd = m_k - 1;
      end else if (m_k <= SLEN) begin
        j  = m_k - 65;
        er = j / 66 + 1;
        if (j % 66 >= 2) begin
          ew = 1'b1; ewd = j % 66 - 2;
        end
      end
      check("s_busy", s_if.busy, (m_k <= SLEN) ? 1 : 0);
      check("s_done", s_if.done, (m_k == SLEN + 1) ? 1 : 0);
      check("s_wren", s_if.wren_a, ew ? 1 : 0);
      if (ew) begin
        check("s_addr", s_if.address_a, er * 64 + ewd);
        check("s_data", s_if.data_a, exp_rows[er][ewd*20 +: 20]);
      end
      if (s_if.wren_a === 1'b1 && s_if.address_a < SROWS * 64) s_mem[s_if.address_a] = s_if.data_a;
    end
  end

  task automatic s_frame(input logic [7:0] rl, input logic c, input bit poke);
    bit got;
    for (int a = 0; a < SROWS * 64; a++) s_mem[a] = '1;
    s_if.rule = rl; s_if.cont = c; s_if.start = 1'b1;
    @(negedge clk108);
    s_if.start = 1'b0;
    s_if.rule  = 8'($urandom);
    s_if.cont  = 1'($urandom);
    got = 1'b0;
    for (int i = 0; i < SLEN + 8 && !got; i++) begin
      s_if.start = poke && (i == 98);
      @(negedge clk108);
      if (s_if.done === 1'b1) got = 1'b1;
    end
    s_if.start = 1'b0;
    check("s_done_seen", got, 1);
    @(negedge clk108);
  endtask

  // Full-size frame with rule 0: only word 32 of row 0 is ever non-zero.
  initial begin : big_run
    int b_wr, b_busy, b_done_k, b_ndone;
    b_if.start = 1'b0; b_if.rule = 8'h00; b_if.cont = 1'b0;
    b_wr = 0; b_busy = 0; b_done_k = -1; b_ndone = 0;
    wait (rst_b == 1'b0);
    @(negedge clk108);
    b_if.start = 1'b1;
    @(negedge clk108);
    b_if.start = 1'b0;
    b_if.rule  = 8'hFF;
    for (int k = 1; k <= BLEN + 3; k++) begin
      if (b_if.wren_a === 1'b1) begin
        check("b_addr", b_if.address_a, b_wr);
        check("b_data", b_if.data_a, (b_wr == 32) ? 1 : 0);
        b_wr++;
      end
      if (b_if.busy === 1'b1) b_busy++;
      if (b_if.done === 1'b1) begin
        b_done_k = k;
        b_ndone++;
      end
      @(negedge clk108);
    end
    check("b_write_count", b_wr, 65536);
    check("b_busy_cycles", b_busy, BLEN);
    check("b_done_cycle", b_done_k, BLEN + 1);
    check("b_done_pulses", b_ndone, 1);
    big_done = 1'b1;
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : main
    s_if.start = 1'b0; s_if.rule = 8'h00; s_if.cont = 1'b0;
    #2;
    check("s_reset_wren", s_if.wren_a, 0);
    check("s_reset_busy", s_if.busy, 0);
    check("s_reset_done", s_if.done, 0);
    check("s_reset_addr", s_if.address_a, 0);
    check("s_reset_data", s_if.data_a, 0);
    check("b_reset_wren", b_if.wren_a, 0);
    check("b_reset_busy", b_if.busy, 0);
    check("b_reset_addr", b_if.address_a, 0);
    @(negedge clk108);
    @(negedge clk108);
    rst_s = 1'b0;
    rst_b = 1'b0;
    @(negedge clk108);

    s_frame(8'h5A, 1'b0, 1'b0);
    check("r5a_seed_w32", s_mem[32], 20'h00001);
    for (int w = 0; w < 64; w++)
      check("r5a_row1", s_mem[64 + w], (w == 31) ? 20'h80000 : (w == 32) ? 20'h00002 : 20'h00000);

    s_frame(8'h01, 1'b0, 1'b0);
    check("r01_row1_w0", s_mem[64], 20'hFFFFF);
    check("r01_row1_w63", s_mem[127], 20'hFFFFF);
    check("r01_row1_w31", s_mem[95], 20'h7FFFF);
    check("r01_row1_w32", s_mem[96], 20'hFFFFC);

    s_frame(8'h09, 1'b1, 1'b0);
    s_frame(8'h09, 1'b0, 1'b0);
    s_frame(8'h1E, 1'b0, 1'b0);
    s_frame(8'h1E, 1'b1, 1'b1);

    s_if.rule = 8'h96; s_if.cont = 1'b0; s_if.start = 1'b1;
    @(negedge clk108);
    s_if.start = 1'b0;
    repeat (200) @(negedge clk108);
    @(posedge clk108);
    #2 rst_s = 1'b1;
    #1;
    check("abort_wren", s_if.wren_a, 0);
    check("abort_busy", s_if.busy, 0);
    check("abort_done", s_if.done, 0);
    @(negedge clk108);
    @(negedge clk108);
    rst_s = 1'b0;
    repeat (80) @(negedge clk108);
    s_frame(8'h1E, 1'b1, 1'b0);
    check("post_abort_seed_w32", s_mem[32], 20'h00001);
    check("post_abort_seed_w0", s_mem[0], 20'h00000);

    for (int f = 0; f < 5; f++) s_frame(8'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));

    for (int i = 0; i < 80000 && !big_done; i++) @(negedge clk108);
    check("big_finished", big_done, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
